// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: decode fields,
// M-extension funct3 values and the sequencer state encoding.
package mdu_pkg;

  localparam logic [3:0] ALU_OP_R = 4'b0010;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Outputs show the quotient/remainder that the current step produces.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   shifted, diff;
  logic            take;

  // The partial remainder stays below the divisor, so bit XLEN of the
  // difference is a clean borrow flag.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign take    = ~diff[XLEN];
  assign rem_o   = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quot_o  = {quo_q[XLEN-2:0], take};

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_o;
      quo_q <= quot_o;
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// stalls the pipeline while iterating and pulses o_done with the result.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [3:0]      i_aluOp,
  input  logic [6:0]      i_funct7,
  input  logic [2:0]      i_funct3,
  input  logic            i_kill,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, done_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [XLEN-1:0]     mcand_q;
  logic [2*XLEN-1:0]   acc_q, acc_nxt, fast_prod;
  logic [XLEN:0]       mstep_sum;

  logic                accept, is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic                div0, ovf, special, fast;
  logic [XLEN-1:0]     mag_a, mag_b, spec_res, quo_nxt, rem_nxt;

  function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic [2:0] f3);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_result(input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r,
                                                 input logic neg, input logic [2:0] f3);
    logic [XLEN-1:0] v;
    v = f3[1] ? r : q;
    return neg ? -v : v;
  endfunction

  assign accept = i_valid && (state_q == ST_IDLE) && (i_aluOp == ALU_OP_R) &&
                  (i_funct7 == M_FUNCT7) && !i_kill;
  assign is_div = i_funct3[2];
  assign a_sgn  = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                  (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign b_sgn  = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                  (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign a_neg  = a_sgn && i_a[XLEN-1];
  assign b_neg  = b_sgn && i_b[XLEN-1];
  assign mag_a  = a_neg ? -i_a : i_a;
  assign mag_b  = b_neg ? -i_b : i_b;
  // Remainders take the dividend's sign; everything else the product/quotient sign.
  assign neg_in = (i_funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

  assign div0     = is_div && (i_b == '0);
  assign ovf      = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                    (i_a == MIN_NEG) && (i_b == '1);
  assign special  = div0 || ovf;
  assign spec_res = div0 ? (i_funct3[1] ? i_a : '1) : (i_funct3[1] ? '0 : i_a);
  assign fast     = !is_div && (FAST_MUL != 0);

  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign mstep_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_nxt   = {mstep_sum, acc_q[XLEN-1:1]};

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk_i      (i_clk),
    .start_i    (accept && is_div && !special),
    .step_i     (state_q == ST_DIV),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quot_o     (quo_nxt),
    .rem_o      (rem_nxt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (special) begin
            state_d  = ST_DONE;
            result_d = spec_res;
          end else if (fast) begin
            state_d  = ST_DONE;
            result_d = mul_result(fast_prod, neg_in, i_funct3);
          end else begin
            state_d = is_div ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = ST_DONE;
          result_d = mul_result(acc_nxt, neg_q, op_q);
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = ST_DONE;
          result_d = div_result(quo_nxt, rem_nxt, neg_q, op_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_kill) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  // Multiplier in the low half of the accumulator is consumed one bit per step.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q    <= i_funct3;
      neg_q   <= neg_in;
      mcand_q <= mag_a;
      acc_q   <= {{XLEN{1'b0}}, mag_b};
    end else if (state_q == ST_MUL) begin
      acc_q <= acc_nxt;
    end
  end

  assign o_stall  = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a 32-bit iterative instance and a 16-bit FAST_MUL instance,
// checked against a plain-arithmetic reference model and literal expectations.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        va, ka, vb, kb;
  logic [3:0]  opa, opb;
  logic [6:0]  f7a, f7b;
  logic [2:0]  f3a, f3b;
  logic [31:0] aa, ba, ra;
  logic [15:0] ab, bb, rb;
  logic        sta, bua, dna, stb, bub, dnb;

  mdu #(.XLEN(32), .FAST_MUL(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(va), .i_aluOp(opa), .i_funct7(f7a),
    .i_funct3(f3a), .i_kill(ka), .i_a(aa), .i_b(ba),
    .o_stall(sta), .o_busy(bua), .o_done(dna), .o_result(ra));

  mdu #(.XLEN(16), .FAST_MUL(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(vb), .i_aluOp(opb), .i_funct7(f7b),
    .i_funct3(f3b), .i_kill(kb), .i_a(ab), .i_b(bb),
    .o_stall(stb), .o_busy(bub), .o_done(dnb), .o_result(rb));

  typedef struct {
    int          due;
    logic [63:0] res;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] last_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: RISC-V M semantics computed with 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input int w, input logic [2:0] f3,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, ua, ub, r, minv;
    longint      sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    ua = a & mask;
    ub = b & mask;
    sa = longint'(ua << (64 - w)); sa = sa >>> (64 - w);
    sb = longint'(ub << (64 - w)); sb = sb >>> (64 - w);
    case (f3)
      F3_MUL:    begin sp = sa * sb; r = 64'(sp); end
      F3_MULH:   begin sp = sa * sb; sp = sp >>> w; r = 64'(sp); end
      F3_MULHSU: begin sp = sa * longint'(ub); sp = sp >>> w; r = 64'(sp); end
      F3_MULHU:  r = (ua * ub) >> w;
      F3_DIV:    r = (ub == 0) ? '1 : ((ua == minv && ub == mask) ? ua : 64'(sa / sb));
      F3_DIVU:   r = (ub == 0) ? '1 : ua / ub;
      F3_REM:    r = (ub == 0) ? ua : ((ua == minv && ub == mask) ? 64'd0 : 64'(sa % sb));
      default:   r = (ub == 0) ? ua : ua % ub;
    endcase
    return r & mask;
  endfunction

  function automatic int lat(input int w, input bit fastm, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    if (!f3[2]) return fastm ? 1 : w + 1;
    if ((b & mask) == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && (a & mask) == minv && (b & mask) == mask) return 1;
    return w + 1;
  endfunction

  // Done pulses and results, every cycle, for both instances.
  always @(negedge clk) begin
    if (!rst) begin
      if (qa.size() > 0 && cyc == qa[0].due) begin
        check("doneA", 64'(dna), 64'd1);
        check("resultA", 64'(ra), qa[0].res);
        void'(qa.pop_front());
      end else begin
        check("idle_doneA", 64'(dna), 64'd0);
      end
      if (qb.size() > 0 && cyc == qb[0].due) begin
        check("doneB", 64'(dnb), 64'd1);
        check("resultB", 64'(rb), qb[0].res);
        void'(qb.pop_front());
      end else begin
        check("idle_doneB", 64'(dnb), 64'd0);
      end
    end
  end

  task automatic req_a(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] f7, input bit exp_acc);
    va = 1'b1; opa = ALU_OP_R; f7a = f7; f3a = f3; aa = a; ba = b;
    @(negedge clk);
    check("stall_c0A", 64'(sta), 64'(exp_acc));
    @(posedge clk); #1;
    va = 1'b0; f7a = M_FUNCT7;
  endtask

  task automatic wait_a();
    int n = 0;
    while (qa.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (qa.size() > 0) begin
      check("timeoutA", 64'(qa.size()), 64'd0);
      qa.delete();
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (qb.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (qb.size() > 0) begin
      check("timeoutB", 64'(qb.size()), 64'd0);
      qb.delete();
    end
  endtask

  task automatic run_a(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] lit, input bit pin);
    exp_t e;
    e.res = ref_op(32, f3, {32'd0, a}, {32'd0, b});
    if (pin) check("modelA", e.res, lit);
    e.due = cyc + lat(32, 1'b0, f3, {32'd0, a}, {32'd0, b});
    qa.push_back(e);
    last_a = e.res;
    req_a(f3, a, b, M_FUNCT7, 1'b1);
    wait_a();
  endtask

  task automatic run_b(input logic [2:0] f3, input logic [15:0] a, input logic [15:0] b,
                       input logic [63:0] lit, input bit pin);
    exp_t e;
    e.res = ref_op(16, f3, {48'd0, a}, {48'd0, b});
    if (pin) check("modelB", e.res, lit);
    e.due = cyc + lat(16, 1'b1, f3, {48'd0, a}, {48'd0, b});
    qb.push_back(e);
    vb = 1'b1; opb = ALU_OP_R; f7b = M_FUNCT7; f3b = f3; ab = a; bb = b;
    @(posedge clk); #1;
    vb = 1'b0;
    wait_b();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int   c0, nst, nbu;
    exp_t e;
    rst = 1'b1; va = 1'b0; ka = 1'b0; vb = 1'b0; kb = 1'b0;
    opa = ALU_OP_R; opb = ALU_OP_R; f7a = M_FUNCT7; f7b = M_FUNCT7;
    f3a = '0; f3b = '0; aa = '0; ba = '0; ab = '0; bb = '0;
    last_a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resultA", 64'(ra), 64'd0);
    check("rst_doneA", 64'(dna), 64'd0);
    check("rst_busyA", 64'(bua), 64'd0);
    check("rst_stallA", 64'(sta), 64'd0);
    check("rst_resultB", 64'(rb), 64'd0);
    check("rst_busyB", 64'(bub), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MUL 7 x -3 with stall/busy window check
    e.res = ref_op(32, F3_MUL, 64'd7, 64'hFFFFFFFD);
    check("modelA_mul", e.res, 64'hFFFFFFEB);
    e.due = cyc + 33;
    qa.push_back(e);
    last_a = e.res;
    req_a(F3_MUL, 32'd7, 32'hFFFFFFFD, M_FUNCT7, 1'b1);
    nst = 0; nbu = 0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (sta) nst++;
      if (bua) nbu++;
    end
    check("stall_cyclesA", 64'(nst), 64'd32);
    check("busy_cyclesA", 64'(nbu), 64'd33);
    check("stall_doneA", 64'(sta), 64'd0);
    @(negedge clk);
    check("busy_afterA", 64'(bua), 64'd0);
    @(posedge clk); #1;

    // High-half multiplies, divides and special cases
    run_a(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE, 1'b1);
    run_a(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000, 1'b1);
    run_a(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF, 1'b1);
    run_a(F3_DIV,    32'hFFFFFFF9, 32'd2,        64'hFFFFFFFD, 1'b1);
    run_a(F3_REM,    32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF, 1'b1);
    run_a(F3_DIVU,   32'd100,      32'd7,        64'd14,       1'b1);
    run_a(F3_REMU,   32'd100,      32'd7,        64'd2,        1'b1);
    run_a(F3_DIV,    32'd5,        32'd0,        64'hFFFFFFFF, 1'b1);
    run_a(F3_REM,    32'd5,        32'd0,        64'd5,        1'b1);
    run_a(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 64'h80000000, 1'b1);
    run_a(F3_REM,    32'h80000000, 32'hFFFFFFFF, 64'd0,        1'b1);
    run_a(F3_DIVU,   32'd9,        32'd0,        64'hFFFFFFFF, 1'b1);
    run_a(F3_REMU,   32'd9,        32'd0,        64'd9,        1'b1);
    run_a(F3_MULH,   32'h80000000, 32'h80000000, 64'h40000000, 1'b1);
    run_a(F3_DIV,    32'd1000,     32'hFFFFFFFD, 64'd0,        1'b0);
    run_a(F3_REM,    32'hFFFFFC18, 32'd7,        64'd0,        1'b0);
    run_a(F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 64'd0,        1'b0);
    run_a(F3_MUL,    32'h12345678, 32'h9ABCDEF0, 64'd0,        1'b0);
    run_a(F3_DIVU,   32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF, 1'b1);

    // Requests while busy are ignored
    e.res = ref_op(32, F3_MUL, 64'd6, 64'd7);
    e.due = cyc + 33;
    qa.push_back(e);
    last_a = e.res;
    req_a(F3_MUL, 32'd6, 32'd7, M_FUNCT7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    va = 1'b1; f3a = F3_DIVU; aa = 32'd100; ba = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    va = 1'b0;
    wait_a();

    // Non-M R-type and kill-with-valid are not accepted
    req_a(F3_MUL, 32'd3, 32'd4, 7'b0000000, 1'b0);
    @(negedge clk);
    check("ignored_f7_busyA", 64'(bua), 64'd0);
    @(posedge clk); #1;
    va = 1'b1; ka = 1'b1; f3a = F3_MUL; aa = 32'd3; ba = 32'd4;
    @(negedge clk);
    check("kill_vs_accept_stallA", 64'(sta), 64'd0);
    @(posedge clk); #1;
    va = 1'b0; ka = 1'b0;
    @(negedge clk);
    check("kill_vs_accept_busyA", 64'(bua), 64'd0);
    @(posedge clk); #1;

    // Kill in cycle 10 of a MUL
    c0 = cyc;
    req_a(F3_MUL, 32'd11, 32'd13, M_FUNCT7, 1'b1);
    while (cyc < c0 + 10) begin
      @(posedge clk); #1;
    end
    ka = 1'b1;
    @(negedge clk);
    check("busy_c10A", 64'(bua), 64'd1);
    @(posedge clk); #1;
    ka = 1'b0;
    @(negedge clk);
    check("kill_busyA", 64'(bua), 64'd0);
    check("kill_stallA", 64'(sta), 64'd0);
    check("kill_resultA", 64'(ra), last_a);
    repeat (30) @(posedge clk);
    #1;

    // Reset in cycle 10 of a MUL
    c0 = cyc;
    req_a(F3_MUL, 32'd11, 32'd13, M_FUNCT7, 1'b1);
    while (cyc < c0 + 10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busyA", 64'(bua), 64'd0);
    check("rst_mid_resultA", 64'(ra), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    run_a(F3_DIVU, 32'd100, 32'd7, 64'd14, 1'b1);

    // FAST_MUL, XLEN=16 instance
    run_b(F3_MUL,   16'h00FF, 16'h0101, 64'hFFFF, 1'b1);
    run_b(F3_DIVU,  16'hFFFF, 16'd3,    64'h5555, 1'b1);
    run_b(F3_MULH,  16'hFFFE, 16'h0003, 64'hFFFF, 1'b1);
    run_b(F3_MULHU, 16'hFFFF, 16'hFFFF, 64'hFFFE, 1'b1);
    run_b(F3_REM,   16'hFFF9, 16'd2,    64'hFFFF, 1'b1);
    run_b(F3_DIV,   16'h8000, 16'hFFFF, 64'h8000, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
